load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Sits between the execute stage and the byte-addressed data memory (word-wide port, registered read data, one-cycle read latency).
- Accepts one load/store request at a time from the core.
- Performs byte, halfword and word accesses, including sign/zero extension for loads.
- Performs read-modify-write for sub-word stores, because the memory only writes whole words. Reports alignment and range faults back to the core.

Parameters:
MEM_SIZE, 64000, memory size in bytes; any access whose bytes fall at or beyond MEM_SIZE faults.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  core presents a request
req_ready  out  1  unit can accept a request
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
req_signed  in  1  sign-extend load result (byte/halfword only)
req_address  in  32  byte address
req_wdata  in  32  store data; byte/halfword taken from the low bits
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  load result; 0 for stores and faults
resp_fault  out  1  qualifies resp_valid; the access was rejected
mem_enable  out  1  to memory enable
mem_write  out  1  to memory write
mem_address  out  32  word-aligned: {req_address[31:2], 2'b00}
mem_wdata  out  32  to memory data_in
mem_rdata  in  32  from memory data_out, valid the cycle after a read is issued

Behaviour:
- Reset (low, async):
  - state IDLE, req_ready=1.
  - resp_valid=0, resp_fault=0, resp_rdata=0.
  - mem_enable=0, mem_write=0, mem_address=0, mem_wdata=0.
  - mem_enable held 0 throughout reset, so the memory's reset-clear path never fires from this unit.
- States: IDLE, RD, CAP, WR, RESP.
- Accept:
  - A request is accepted on a rising edge with req_valid && req_ready. req_ready=1 only in IDLE.
  - Address, size, signed, write and wdata are latched at accept.
- Fault check at accept, in priority order:
  1. size 11.
  2. Halfword with addr[0]=1.
  3. Word with addr[1:0]!=0.
  4. Last byte of the access >= MEM_SIZE.
  - On fault: go to RESP with resp_fault=1 and rdata=0. No memory cycle is issued.
- Paths (cycle 0 = accept edge; resp_valid high during the cycle shown):
  - Load: RD (mem_enable=1, mem_write=0) -> CAP (mem_rdata sampled, lane selected) -> RESP. resp_valid in cycle 3.
  - Word store: WR (mem_enable=1, mem_write=1, mem_wdata=req_wdata) -> RESP. resp_valid in cycle 2.
  - Byte/halfword store: RD -> CAP (merge new lane into read word) -> WR -> RESP. resp_valid in cycle 4.
  - Fault: RESP. resp_valid in cycle 1.
- Lane select:
  - Byte lane = addr[1:0]; halfword lane = addr[1]. Little-endian: byte 0 = bits [7:0].
  - Zero-extend, or sign-extend from bit 7/15 when req_signed.
  - req_signed is ignored for words and stores.
- Merge: only the addressed byte(s) are replaced; all other bytes are written back unchanged.
- RESP:
  - Lasts exactly one cycle, then returns to IDLE.
  - resp_rdata and resp_fault stay stable until the next RESP. resp_valid is a pulse.
- mem_enable is asserted only in RD and WR. Exactly one memory cycle per state.
- Reset mid-operation:
  - Request dropped, no response, no memory write.
  - A write in progress at the reset edge is abandoned, because mem_enable drops asynchronously.

Optional Feature:
LSU_UNALIGNED_ROTATE_EN
- Defined:
  - Word loads with addr[1:0]!=0 do not fault. They read the aligned word and return it rotated right by 8*addr[1:0] (legacy ARM LDR behaviour), with the same 3-cycle latency.
  - Misaligned word stores and halfword accesses still fault.
  - The range check uses the aligned word.
- Undefined: every misaligned word load faults, as above.

Test Plan:
(Word at 0x100 preloaded 0x8899AABB.)
- Sub-word loads: LDRSB 0x101 -> rdata 0xFFFFFFAA, fault 0, resp_valid 3 cycles after accept. LDRB 0x103 -> 0x00000088. LDRSH 0x102 -> 0xFFFF8899. LDRH 0x100 -> 0x0000AABB.
- Sub-word store: STRB 0x102, wdata 0x12345677 -> mem bus shows one read then one write of 0x8877AABB to 0x100. resp_valid in cycle 4. LDR 0x100 then returns 0x8877AABB.
- Word store: STR 0x104, 0xDEADBEEF -> single write, no read, resp_valid in cycle 2. LDR 0x104 returns 0xDEADBEEF.
- Faults (MEM_SIZE=64000):
  - LDRH 0x101, size 11, and LDR 0x102 each -> resp_fault=1, rdata 0, resp_valid in cycle 1, mem_enable never high.
  - LDRB 0xF9FF succeeds.
  - LDRB 0xFA00 and LDR 0xF9FD both fault.
- Reset mid-store: reset asserted in CAP of STRB 0x100 -> mem_enable 0 immediately, memory unchanged, no resp_valid. req_ready=1 after release.
- Macro defined: LDR 0x101 -> 0xBB8899AA. Macro undefined: LDR 0x101 faults.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-wide, one-cycle-latency data memory.
// Optional LSU_UNALIGNED_ROTATE_EN: misaligned word loads return the aligned word rotated right.
module load_store_unit #(
    parameter int MEM_SIZE = 64000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_enable,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    localparam logic [32:0] MEM_LIMIT = 33'(MEM_SIZE);

    state_t      state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic        write_q, write_d;
    logic [15:0] wdata_q, wdata_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_fault_q, resp_fault_d;
    logic        mem_enable_q, mem_enable_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic [32:0] base;
    logic [32:0] span;
    logic [32:0] last_byte;
    logic        misaligned;
    logic        fault;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] merged;

    // 33-bit range arithmetic so addresses near 2^32 cannot wrap below the limit
    always_comb begin
        base       = {1'b0, req_address};
        misaligned = 1'b0;
        case (req_size)
            2'b00: span = 33'd0;
            2'b01: begin
                span       = 33'd1;
                misaligned = req_address[0];
            end
            default: begin
                span       = 33'd3;
                misaligned = (req_address[1:0] != 2'b00);
            end
        endcase
`ifdef LSU_UNALIGNED_ROTATE_EN
        if (!req_write && req_size == 2'b10) begin
            misaligned = 1'b0;
            base[1:0]  = 2'b00;
        end
`endif
        last_byte = base + span;
        fault     = (req_size == 2'b11) || misaligned || (last_byte >= MEM_LIMIT);
    end

    always_comb begin
        case (lane_q)
            2'b00:   byte_sel = mem_rdata[7:0];
            2'b01:   byte_sel = mem_rdata[15:8];
            2'b10:   byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   load_data = sgn_q ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
            2'b01:   load_data = sgn_q ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
            default: begin
`ifdef LSU_UNALIGNED_ROTATE_EN
                case (lane_q)
                    2'b00:   load_data = mem_rdata;
                    2'b01:   load_data = {mem_rdata[7:0], mem_rdata[31:8]};
                    2'b10:   load_data = {mem_rdata[15:0], mem_rdata[31:16]};
                    default: load_data = {mem_rdata[23:0], mem_rdata[31:24]};
                endcase
`else
                load_data = mem_rdata;
`endif
            end
        endcase
    end

    // Sub-word store: splice the new lane into the word just read back
    always_comb begin
        merged = mem_rdata;
        if (size_q == 2'b00) begin
            case (lane_q)
                2'b00:   merged[7:0]   = wdata_q[7:0];
                2'b01:   merged[15:8]  = wdata_q[7:0];
                2'b10:   merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (size_q == 2'b01) begin
            if (lane_q[1]) merged[31:16] = wdata_q;
            else           merged[15:0]  = wdata_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        lane_d        = lane_q;
        size_d        = size_q;
        sgn_d         = sgn_q;
        write_d       = write_q;
        wdata_d       = wdata_q;
        req_ready_d   = 1'b0;
        resp_valid_d  = 1'b0;
        resp_rdata_d  = resp_rdata_q;
        resp_fault_d  = resp_fault_q;
        mem_enable_d  = 1'b0;
        mem_write_d   = 1'b0;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    req_ready_d   = 1'b0;
                    lane_d        = req_address[1:0];
                    size_d        = req_size;
                    sgn_d         = req_signed;
                    write_d       = req_write;
                    wdata_d       = req_wdata[15:0];
                    mem_address_d = {req_address[31:2], 2'b00};
                    if (fault) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                        resp_rdata_d = 32'd0;
                    end else if (req_write && req_size == 2'b10) begin
                        state_d      = WR;
                        mem_enable_d = 1'b1;
                        mem_write_d  = 1'b1;
                        mem_wdata_d  = req_wdata;
                    end else begin
                        state_d      = RD;
                        mem_enable_d = 1'b1;
                    end
                end
            end
            RD: state_d = CAP;
            CAP: begin
                if (write_q) begin
                    state_d      = WR;
                    mem_enable_d = 1'b1;
                    mem_write_d  = 1'b1;
                    mem_wdata_d  = merged;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_fault_d = 1'b0;
                    resp_rdata_d = load_data;
                end
            end
            WR: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_fault_d = 1'b0;
                resp_rdata_d = 32'd0;
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // Async clear drops mem_enable immediately, abandoning any write in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            lane_q        <= 2'd0;
            size_q        <= 2'd0;
            sgn_q         <= 1'b0;
            write_q       <= 1'b0;
            wdata_q       <= 16'd0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= 32'd0;
            resp_fault_q  <= 1'b0;
            mem_enable_q  <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= 32'd0;
            mem_wdata_q   <= 32'd0;
        end else begin
            state_q       <= state_d;
            lane_q        <= lane_d;
            size_q        <= size_d;
            sgn_q         <= sgn_d;
            write_q       <= write_d;
            wdata_q       <= wdata_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
            resp_fault_q  <= resp_fault_d;
            mem_enable_q  <= mem_enable_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_fault  = resp_fault_q;
    assign mem_enable  = mem_enable_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;

endmodule
